// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Single-instruction sequencer between an instruction source and
//            the reg_bank / ALUX pair. Accepts one instruction through a
//            valid/ready handshake, reads both operands, launches ALUX, waits
//            for done (bounded by TIMEOUT), optionally writes the result back
//            and reports completion.
// Ports    : clock/reset          - rising-edge clock, async active-high reset
//            instr_*              - instruction handshake and fields
//            seloutA/B, enrregA/B, cnstA/B - reg_bank read side
//            regwen, selwreg, endwreg, wdata - reg_bank write side
//            alu_opr, alu_start, alu_result, alu_done - ALUX interface
//            busy, cmpl, cmpl_err, cmpl_data - status / completion report
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 4,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_opr,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [1:0]        instr_endw,
    input  logic              instr_cnstA,
    input  logic              instr_cnstB,
    input  logic              instr_wb,
    output logic [REG_AW-1:0] seloutA,
    output logic [REG_AW-1:0] seloutB,
    output logic              enrregA,
    output logic              enrregB,
    output logic              cnstA,
    output logic              cnstB,
    output logic              regwen,
    output logic [REG_AW-1:0] selwreg,
    output logic [1:0]        endwreg,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        alu_opr,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              busy,
    output logic              cmpl,
    output logic              cmpl_err,
    output logic [DATA_W-1:0] cmpl_data
);

    localparam logic [7:0] c_lat_last = 8'(RD_LAT - 1);
    localparam logic [7:0] c_to_last  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t state_q, state_d;

    // Shared counter: read-latency count in LATCH, timeout count in WAIT.
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        opr_q, opr_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [1:0]        endw_q, endw_d;
    logic              ca_q, ca_d, cb_q, cb_d, wb_q, wb_d, err_q, err_d;
    logic [DATA_W-1:0] res_q, res_d;

    // Registered outputs
    logic              ready_q, ready_d, busy_q, busy_d;
    logic              enr_q, enr_d, cnstA_q, cnstA_d, cnstB_q, cnstB_d;
    logic [REG_AW-1:0] selA_q, selA_d, selB_q, selB_d, selw_q, selw_d;
    logic              regwen_q, regwen_d, start_q, start_d;
    logic [1:0]        endwreg_q, endwreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, cdata_q, cdata_d;
    logic [3:0]        aopr_q, aopr_d;
    logic              cmpl_q, cmpl_d, cerr_q, cerr_d;
    logic              w_active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        endw_d  = endw_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        wb_d    = wb_q;
        err_d   = err_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid && ready_q) begin
                    opr_d   = instr_opr;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    rd_d    = instr_rd;
                    endw_d  = instr_endw;
                    ca_d    = instr_cnstA;
                    cb_d    = instr_cnstB;
                    wb_d    = instr_wb;
                    err_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = 8'd0;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                if (cnt_q == c_lat_last) begin
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_START: begin
                // alu_done is deliberately not looked at here
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done is tested first so it wins on the last allowed cycle
                if (alu_done) begin
                    res_d   = alu_result;
                    state_d = wb_q ? S_WRITE : S_DONE;
                end else if (cnt_q == c_to_last) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they belong to.
        w_active  = (state_d != S_IDLE);
        ready_d   = !w_active;
        busy_d    = w_active;
        enr_d     = (state_d == S_READ);
        selA_d    = w_active ? rs1_d : '0;
        selB_d    = w_active ? rs2_d : '0;
        cnstA_d   = w_active ? ca_d : 1'b0;
        cnstB_d   = w_active ? cb_d : 1'b0;
        start_d   = (state_d == S_START);
        aopr_d    = (state_d == S_START || state_d == S_WAIT) ? opr_d : 4'd0;
        regwen_d  = (state_d == S_WRITE);
        selw_d    = (state_d == S_WRITE) ? rd_d : '0;
        endwreg_d = (state_d == S_WRITE) ? endw_d : 2'd0;
        wdata_d   = (state_d == S_WRITE) ? res_d : '0;
        cmpl_d    = (state_d == S_DONE);
        cerr_d    = (state_d == S_DONE) ? err_d : 1'b0;
        // On timeout the previous result stays visible
        cdata_d   = (state_d == S_DONE && !err_d) ? res_d : cdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            opr_q     <= 4'd0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            endw_q    <= 2'd0;
            ca_q      <= 1'b0;
            cb_q      <= 1'b0;
            wb_q      <= 1'b0;
            err_q     <= 1'b0;
            res_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            enr_q     <= 1'b0;
            selA_q    <= '0;
            selB_q    <= '0;
            cnstA_q   <= 1'b0;
            cnstB_q   <= 1'b0;
            start_q   <= 1'b0;
            aopr_q    <= 4'd0;
            regwen_q  <= 1'b0;
            selw_q    <= '0;
            endwreg_q <= 2'd0;
            wdata_q   <= '0;
            cmpl_q    <= 1'b0;
            cerr_q    <= 1'b0;
            cdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opr_q     <= opr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            endw_q    <= endw_d;
            ca_q      <= ca_d;
            cb_q      <= cb_d;
            wb_q      <= wb_d;
            err_q     <= err_d;
            res_q     <= res_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            enr_q     <= enr_d;
            selA_q    <= selA_d;
            selB_q    <= selB_d;
            cnstA_q   <= cnstA_d;
            cnstB_q   <= cnstB_d;
            start_q   <= start_d;
            aopr_q    <= aopr_d;
            regwen_q  <= regwen_d;
            selw_q    <= selw_d;
            endwreg_q <= endwreg_d;
            wdata_q   <= wdata_d;
            cmpl_q    <= cmpl_d;
            cerr_q    <= cerr_d;
            cdata_q   <= cdata_d;
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign enrregA     = enr_q;
    assign enrregB     = enr_q;
    assign seloutA     = selA_q;
    assign seloutB     = selB_q;
    assign cnstA       = cnstA_q;
    assign cnstB       = cnstB_q;
    assign alu_start   = start_q;
    assign alu_opr     = aopr_q;
    assign regwen      = regwen_q;
    assign selwreg     = selw_q;
    assign endwreg     = endwreg_q;
    assign wdata       = wdata_q;
    assign cmpl        = cmpl_q;
    assign cmpl_err    = cerr_q;
    assign cmpl_data   = cdata_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Sequencer that drives the register bank's read and write ports and the ALUX start/done interface.
- Accepts one instruction via valid/ready: operand registers, ALU opcode, destination register, write mode.
- Reads both operands, launches ALUX, waits for done with timeout, writes the result back, reports completion.
- Sits between the instruction source and the reg_bank/ALUX pair; replaces bench-driven register writes.

Parameters:
- DATA_W, 64, data path width
- REG_AW, 4, register address width (16 registers)
- RD_LAT, 1, cycles from enrregA/B assertion to valid outA/outB (1..4)
- TIMEOUT, 255, maximum WAIT cycles for alu_done (1..255)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller idle and accepting
- instr_opr  in  4  ALU opcode
- instr_rs1  in  REG_AW  operand A register
- instr_rs2  in  REG_AW  operand B register
- instr_rd  in  REG_AW  destination register
- instr_endw  in  2  write mode, forwarded unchanged to endwreg
- instr_cnstA  in  1  forwarded to cnstA
- instr_cnstB  in  1  forwarded to cnstB
- instr_wb  in  1  1 = write result back
- seloutA  out  REG_AW  reg_bank read select A
- seloutB  out  REG_AW  reg_bank read select B
- enrregA  out  1  read enable A
- enrregB  out  1  read enable B
- cnstA  out  1  constant select A
- cnstB  out  1  constant select B
- regwen  out  1  reg_bank write enable
- selwreg  out  REG_AW  write address
- endwreg  out  2  write mode
- wdata  out  DATA_W  write data (connects to reg_bank inA)
- alu_opr  out  4  ALUX opcode
- alu_start  out  1  ALUX start pulse
- alu_result  in  DATA_W  ALUX outAB
- alu_done  in  1  ALUX done
- busy  out  1  high in every non-IDLE state
- cmpl  out  1  one-cycle completion pulse
- cmpl_err  out  1  timeout flag, valid with cmpl
- cmpl_data  out  DATA_W  last result, held until next cmpl

Behaviour:
- Reset (async) state and outputs:
  - State IDLE.
  - All outputs 0 except instr_ready = 1.
  - Timeout counter and captured fields cleared.
  - Applies immediately mid-operation: regwen/alu_start drop at once, no partial write-back, no cmpl.
- All outputs registered; state changes on the rising edge of clock.
- IDLE:
  - instr_ready = 1.
  - Accept on instr_valid && instr_ready at a clock edge: capture all instr_* fields, go to READ.
  - instr_valid in any other state is ignored (instr_ready = 0).
- READ (1 cycle):
  - enrregA = enrregB = 1; seloutA = rs1, seloutB = rs2, cnstA/cnstB from the instruction.
  - Selects and cnst held stable until state returns to IDLE.
  - enrreg drops on leaving READ.
- LATCH: RD_LAT cycles, operands settling. Then START.
- START (1 cycle):
  - alu_start = 1; alu_opr = opr (held stable through WAIT).
  - alu_done is ignored in this cycle.
  - Clear timeout counter, go to WAIT.
- WAIT:
  - Sample alu_done each edge.
  - On done: capture alu_result; go to WRITE if wb = 1, else DONE.
  - Counter increments each WAIT cycle without done.
  - After TIMEOUT cycles without done: set err, go to DONE, no write.
  - Done on the final allowed cycle wins over timeout.
- WRITE (1 cycle):
  - regwen = 1, selwreg = rd, endwreg = endw, wdata = captured result.
  - rd equal to rs1/rs2 is legal: reads completed earlier.
- DONE (1 cycle):
  - cmpl = 1; cmpl_err = err; cmpl_data updated to the result (unchanged on timeout).
  - Return to IDLE.
- Latency (RD_LAT = 1, done on first WAIT cycle): cmpl high in the 6th cycle after the accepting edge; instr_ready high the cycle after.
- Back-to-back: the next instruction can be accepted on the first IDLE edge.

Test Plan:
1. Reset → instr_ready = 1, all other outputs 0. Assert reset during WAIT → regwen never pulses, cmpl stays 0, instr_ready = 1 immediately.
2. Nominal add: rs1 = 2, rs2 = 3, rd = 5, wb = 1, endw = 2'b00, ALU model returns 64'h0000_0000_0000_0007 two cycles after start:
   - exactly one alu_start pulse;
   - one regwen pulse with selwreg = 5, wdata = 7;
   - cmpl = 1, cmpl_err = 0, cmpl_data = 7.
3. wb = 0, rd = 9, result 64'hAB00_75C1_5600_EB80 → no regwen pulse; cmpl_data = 64'hAB00_75C1_5600_EB80.
4. Timeout (TIMEOUT = 4): alu_done never asserted → cmpl after exactly 4 WAIT cycles, cmpl_err = 1, no regwen, cmpl_data keeps its previous value.
5. Boundary: done on the 4th WAIT cycle with TIMEOUT = 4 → cmpl_err = 0, write-back occurs. alu_done held high during START → ignored, result captured from the WAIT cycle.
6. Handshake: instr_valid held high for 3 instructions, rd = rs1 = 1 in each:
   - each accepted only in IDLE;
   - fields changed while busy have no effect;
   - 3 cmpl pulses, with reads/writes to register 1 correctly ordered.
